nibble_serial_addsub: RTL and testbench
=======================================

Name: nibble_serial_addsub

Overview:
- Multi-cycle W-bit add/subtract unit that processes one 4-bit nibble per clock, least significant nibble first.
- Each nibble goes through a single 4-bit carry-lookahead slice; a registered carry links one nibble to the next.
- Subtraction is the inverse path of the datapath adder: a - b is computed as a + ~b + 1.
- Used where area matters more than latency, e.g. the address/offset arithmetic sequencer; start/done handshake toward the controller.

Parameters:
- W, 32, operand width in bits; must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when ready.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  first operand; sampled with start.
- b  input  W  second operand; sampled with start.
- ready  output  1  high in IDLE and DONE; start accepted when high.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse: result and flags just updated.
- result  output  W  last completed sum/difference.
- cout  output  1  final carry out. For sub, 1 means no borrow (a >= b unsigned).
- ovf  output  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides all other inputs.
- Reset values: state=IDLE; ready=1; busy=0; done=0; result=0; cout=0; ovf=0; zero=1; internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - Latch a, and b XOR {W{sub}}.
  - Carry register := sub.
  - Nibble counter := 0.
  - Accumulator shift register cleared.
- RUN, each cycle:
  - nibble k = counter: s = a[4k+3:4k] + b'[4k+3:4k] + c.
  - s goes to the top of the accumulator while the accumulator shifts right by 4.
  - c := nibble carry out.
  - Carry into bit 3 of nibble k is also captured, for ovf.
  - counter increments.
- RUN -> DONE after nibble W/4-1. On that same edge:
  - result := full accumulator.
  - cout := final carry; ovf := c3 XOR c4 of the top nibble; zero := (full result == 0).
- DONE lasts exactly one cycle with done=1.
  - start=1 in DONE -> RUN directly, latching as above.
  - Otherwise -> IDLE.
- Latency: start sampled at edge N -> done high in the cycle after edge N+W/4. For W=32, that is 8 edges after the start edge.
- Throughput: back-to-back starts give one result every W/4+1 cycles.
- start while busy (RUN) is ignored; it is not queued.
- result and flags hold their last completed values while busy and in IDLE. They change only on the edge that enters DONE.
- Changes on a, b or sub after acceptance have no effect.
- rst during RUN:
  - Operation is abandoned; all outputs return to reset values on the next edge.
  - No done pulse is produced.
- Unsigned wrap-around is natural modulo 2^W. Example: 0xFFFFFFFF+1 -> 0, cout=1.

Test Plan:
- Reset then idle -> ready=1, busy=0, done=0, result=0, zero=1. start=1 with rst=1 -> stays IDLE.
- W=32, add 0x12345678+0x0F0F0F0F -> done exactly 8 edges after the start edge; result=0x21436587; cout=0, ovf=0, zero=0.
- Subtract 5-7 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0. Subtract 7-7 -> result=0, zero=1, cout=1.
- Overflow cases:
  - 0x7FFFFFFF+1 -> result=0x80000000, ovf=1, cout=0.
  - 0x80000000-1 -> result=0x7FFFFFFF, ovf=1, cout=1.
  - 0xFFFFFFFF+1 -> result=0, cout=1, ovf=0, zero=1.
- Timing and handshake:
  - start held high for 20 cycles -> exactly 2 done pulses, 9 cycles apart.
  - Operands changed mid-RUN -> first result unaffected.
- Assert rst at RUN cycle 4 after a prior result of 0xAAAA0000 -> next edge: result=0, zero=1, ready=1; no done pulse; a new start completes correctly.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial W-bit adder/subtractor.
// One 4-bit carry-lookahead slice is reused for every nibble, least significant
// nibble first. A registered carry links consecutive nibbles. Subtraction
// feeds the slice with ~b and a carry-in of 1, so a - b = a + ~b + 1.
module nibble_serial_addsub #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NN = W / 4;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic           load;
  logic           last;

  logic [W-1:0]   a_reg, b_reg, acc_reg, acc_next;
  logic           c_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   result_reg;
  logic           cout_reg, ovf_reg, zero_reg;

  // Operands viewed as nibble arrays so the counter selects the active slice.
  logic [3:0]     a_nib [NN];
  logic [3:0]     b_nib [NN];

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // Carry-lookahead slice for the nibble selected by the counter.
  logic [3:0] an, bn, g, p, sum;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries for one nibble.
  always_comb begin
    an   = a_nib[cnt_reg];
    bn   = b_nib[cnt_reg];
    g    = an & bn;
    p    = an ^ bn;
    c[0] = c_reg;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum      = p ^ c[3:0];
    acc_next = {sum, acc_reg[W-1:4]};
  end

  assign last = (cnt_reg == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs; load marks an accepted start.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on start, process one nibble per RUN cycle,
  // and publish result and flags only on the edge that completes the top nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b1;
    end else if (load) begin
      a_reg   <= a;
      b_reg   <= b ^ {W{sub}};
      c_reg   <= sub;
      cnt_reg <= '0;
      acc_reg <= '0;
    end else if (state_reg == RUN) begin
      acc_reg <= acc_next;
      c_reg   <= c[4];
      cnt_reg <= cnt_reg + 1'b1;
      if (last) begin
        result_reg <= acc_next;
        cout_reg   <= c[4];
        ovf_reg    <= c[3] ^ c[4];
        zero_reg   <= (acc_next == '0);
      end
    end
  end

  assign result = result_reg;
  assign cout   = cout_reg;
  assign ovf    = ovf_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized self-checking bench for nibble_serial_addsub (W=32).
// Expected values come from plain integer arithmetic on the operands.
module tb_nibble_serial_addsub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout, ovf, zero;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] prev_result = '0;

  nibble_serial_addsub #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned sum/difference, carry as "no borrow" for sub,
  // signed overflow as the exact signed result falling outside W bits.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic co, output logic ov);
    longint sx, sy, sr;
    logic [W:0] wide;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      r  = wide[W-1:0];
      co = wide[W];
      sr = sx + sy;
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] er,
                               input logic eco, input logic eov);
    chk({tag, ".result"}, result, er);
    chk({tag, ".cout"},   cout,   eco);
    chk({tag, ".ovf"},    ovf,    eov);
    chk({tag, ".zero"},   zero,   (er == '0));
  endtask

  // One operation: start, scramble inputs after acceptance, wait for done.
  task automatic run_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic s);
    logic [W-1:0] er;
    logic eco, eov;
    int edges;
    bit seen;
    model(x, y, s, er, eco, eov);
    chk({tag, ".ready"}, ready, 1'b1);
    start = 1'b1; a = x; b = y; sub = s;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    edges = 0;
    seen  = 0;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1;
      else if (edges == 4) chk({tag, ".hold"}, result, prev_result);
    end
    chk({tag, ".done_seen"}, seen, 1'b1);
    chk({tag, ".latency"}, edges, 8);
    check_outputs(tag, er, eco, eov);
    $display("op %s: %08h %s %08h -> %08h cout=%0b ovf=%0b zero=%0b",
             tag, x, s ? "-" : "+", y, result, cout, ovf, zero);
    prev_result = er;
  endtask

  initial begin
    int dcount, d1, d2, k;
    logic [W-1:0] er, x, y;
    logic eco, eov, s;

    rst = 1'b1; start = 1'b1; sub = 1'b0; a = '1; b = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", ready, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.result", result, '0);
    chk("rst.zero", zero, 1'b1);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle.busy", busy, 1'b0);

    run_op("add_basic", 32'h12345678, 32'h0F0F0F0F, 1'b0);
    run_op("sub_5_7",   32'd5, 32'd7, 1'b1);
    run_op("sub_7_7",   32'd7, 32'd7, 1'b1);
    run_op("ovf_pos",   32'h7FFFFFFF, 32'd1, 1'b0);
    run_op("ovf_neg",   32'h80000000, 32'd1, 1'b1);
    run_op("wrap",      32'hFFFFFFFF, 32'd1, 1'b0);

    // start held high: back-to-back operations every W/4+1 cycles
    model(32'hDEADBEEF, 32'h01234567, 1'b0, er, eco, eov);
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h01234567; sub = 1'b0;
    dcount = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
        check_outputs("b2b", er, eco, eov);
      end
    end
    start = 1'b0;
    chk("b2b.count", dcount, 2);
    chk("b2b.spacing", d2 - d1, 9);
    $display("op b2b: %0d done pulses at cycles %0d and %0d", dcount, d1, d2);
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b.tail_done", done, 1'b1);
    prev_result = er;

    // reset in the middle of a run after a known prior result
    run_op("pre_rst", 32'hAAAA0000, 32'h00000000, 1'b0);
    start = 1'b1; a = 32'h11111111; b = 32'h22222222; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.result", result, '0);
    chk("midrst.zero", zero, 1'b1);
    chk("midrst.ready", ready, 1'b1);
    chk("midrst.busy", busy, 1'b0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("midrst.no_done", dcount, 0);
    $display("op midrst: run abandoned, %0d done pulses afterwards", dcount);
    prev_result = '0;
    run_op("after_rst", 32'h00C0FFEE, 32'h00001234, 1'b1);

    // randomized operations, with some operand shaping toward edge cases
    for (int i = 0; i < 30; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: y = x;
        1: x = {1'b0, {(W-1){1'b1}}} - W'($urandom_range(0, 3));
        2: x = {1'b1, {(W-1){1'b0}}} + W'($urandom_range(0, 3));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), x, y, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
